sccb_init_seq: RTL and testbench

SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

---
 rtl/sccb_init_seq.sv | 164 ++++++++++++++++
 tb/tb_sccb_init_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_seq.sv
// Walks a table ROM and issues SCCB register writes and ms delays until an end marker or the last entry.
// Each write waits for SCCB_BUSY low before strobing; a write whose BUSY never drops aborts the run with ERR.
module sccb_init_seq #(
   parameter int TBL_AW       = 8,
   parameter int MS_CYCLES    = 100000,
   parameter int BUSY_TIMEOUT = 10000000
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   output logic [TBL_AW-1:0] TBL_ADDR,
   input  logic [23:0]       TBL_DATA,
   output logic [23:0]       IIC_WDATA,
   output logic              IIC_WENBL,
   input  logic              SCCB_BUSY,
   output logic              ACTIVE,
   output logic              DONE,
   output logic              ERR
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_SETTLE, S_WAITBUSY, S_DELAY, S_FINISH
   } state_t;

   localparam logic [31:0]       TO_LAST   = 32'(BUSY_TIMEOUT - 1);
   localparam logic [31:0]       PRE_LAST  = 32'(MS_CYCLES - 1);
   localparam logic [TBL_AW-1:0] ADDR_LAST = '1;

   state_t            state_q, state_d;
   logic [TBL_AW-1:0] addr_q, addr_d;
   logic [23:0]       wdata_q, wdata_d;
   logic              wenbl_q, wenbl_d;
   logic              active_q, active_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [31:0]       to_cnt_q, to_cnt_d;
   logic [31:0]       pre_q, pre_d;
   logic [15:0]       dly_q, dly_d;
   logic              adv;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wenbl_d  = 1'b0;
      active_d = active_q;
      done_d   = done_q;
      err_d    = err_q;
      to_cnt_d = to_cnt_q;
      pre_d    = pre_q;
      dly_d    = dly_q;
      adv      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               addr_d   = '0;
               done_d   = 1'b0;
               err_d    = 1'b0;
               active_d = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            if (TBL_DATA[23:16] == 8'hFF) begin
               state_d = S_FINISH;
            end else if (TBL_DATA[23:16] == 8'hFE) begin
               if (TBL_DATA[15:0] == 16'd0) begin
                  adv = 1'b1;
               end else begin
                  dly_d   = TBL_DATA[15:0];
                  pre_d   = '0;
                  state_d = S_DELAY;
               end
            end else begin
               wdata_d = TBL_DATA;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!SCCB_BUSY) begin
               wenbl_d = 1'b1;
               state_d = S_SETTLE;
            end
         end
         // strobe is visible this cycle; BUSY rises on the next
         S_SETTLE: begin
            to_cnt_d = '0;
            state_d  = S_WAITBUSY;
         end
         S_WAITBUSY: begin
            if (!SCCB_BUSY) begin
               adv = 1'b1;
            end else if (to_cnt_q == TO_LAST) begin
               err_d    = 1'b1;
               active_d = 1'b0;
               state_d  = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 32'd1;
            end
         end
         S_DELAY: begin
            if (pre_q == PRE_LAST) begin
               pre_d = '0;
               if (dly_q == 16'd1) adv = 1'b1;
               else                dly_d = dly_q - 16'd1;
            end else begin
               pre_d = pre_q + 32'd1;
            end
         end
         S_FINISH: begin
            done_d   = 1'b1;
            active_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // the last table entry finishes the run instead of wrapping to 0
      if (adv) begin
         if (addr_q == ADDR_LAST) begin
            state_d = S_FINISH;
         end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wenbl_q  <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         to_cnt_q <= '0;
         pre_q    <= '0;
         dly_q    <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wenbl_q  <= wenbl_d;
         active_q <= active_d;
         done_q   <= done_d;
         err_q    <= err_d;
         to_cnt_q <= to_cnt_d;
         pre_q    <= pre_d;
         dly_q    <= dly_d;
      end
   end

   assign TBL_ADDR  = addr_q;
   assign IIC_WDATA = wdata_q;
   assign IIC_WENBL = wenbl_q;
   assign ACTIVE    = active_q;
   assign DONE      = done_q;
   assign ERR       = err_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: 4-entry ROM, 10-cycle ms, 100-cycle BUSY timeout, SCCB model holding BUSY 50 cycles.
module tb_sccb_init_seq;

   logic        CLK;
   logic        RST_N;
   logic        START;
   logic [1:0]  TBL_ADDR;
   logic [23:0] TBL_DATA;
   logic [23:0] IIC_WDATA;
   logic        IIC_WENBL;
   logic        SCCB_BUSY;
   logic        ACTIVE;
   logic        DONE;
   logic        ERR;

   sccb_init_seq #(.TBL_AW(2), .MS_CYCLES(10), .BUSY_TIMEOUT(100)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
      .IIC_WDATA(IIC_WDATA), .IIC_WENBL(IIC_WENBL), .SCCB_BUSY(SCCB_BUSY),
      .ACTIVE(ACTIVE), .DONE(DONE), .ERR(ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // synchronous table ROM
   logic [23:0] rom [4];
   always @(posedge CLK) TBL_DATA <= rom[TBL_ADDR];

   // SCCB controller model plus strobe logger
   logic        model_rst;
   logic        stuck_mode;
   int          busy_cnt;
   logic        stuck_q;
   logic        wenbl_prev;
   int          strobe_cnt;
   int          dbl_cnt;
   logic [23:0] strobe_log [8];

   assign SCCB_BUSY = (busy_cnt != 0) || stuck_q;

   always @(posedge CLK) begin
      if (model_rst) begin
         busy_cnt   <= 0;
         stuck_q    <= 1'b0;
         wenbl_prev <= 1'b0;
         strobe_cnt <= 0;
         dbl_cnt    <= 0;
      end else begin
         wenbl_prev <= IIC_WENBL;
         if (IIC_WENBL) begin
            busy_cnt <= 50;
            if (stuck_mode) stuck_q <= 1'b1;
            if (strobe_cnt < 8) strobe_log[strobe_cnt] <= IIC_WDATA;
            strobe_cnt <= strobe_cnt + 1;
            if (wenbl_prev) dbl_cnt <= dbl_cnt + 1;
         end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
         end
      end
   end

   typedef struct packed {
      logic [3:0][23:0] rom;
      logic             stuck;
      logic [3:0]       n_strobe;
      logic [23:0]      d0;
      logic [23:0]      d1;
      logic             done;
      logic             err;
      logic [1:0]       addr;
   } vec_t;

   vec_t vecs [5];
   int   n_chk;
   int   n_fail;

   function automatic vec_t mk(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2,
                               input logic [23:0] e3, input logic stuck, input logic [3:0] n,
                               input logic [23:0] d0, input logic [23:0] d1, input logic done,
                               input logic err, input logic [1:0] addr);
      vec_t v;
      v.rom      = {e3, e2, e1, e0};
      v.stuck    = stuck;
      v.n_strobe = n;
      v.d0       = d0;
      v.d1       = d1;
      v.done     = done;
      v.err      = err;
      v.addr     = addr;
      return v;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic model_clear();
      model_rst = 1'b1;
      tick();
      model_rst = 1'b0;
   endtask

   task automatic pulse_start();
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int c;
      c = 0;
      while (ACTIVE && c < budget) begin
         tick();
         c++;
      end
      if (ACTIVE) chk({name, "_run_timeout"}, 32'(ACTIVE), 32'd0);
   endtask

   task automatic load_rom(input logic [3:0][23:0] r);
      for (int i = 0; i < 4; i++) rom[i] = r[i];
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      string nm;
      v  = vecs[idx];
      nm = $sformatf("vec%0d", idx);
      load_rom(v.rom);
      stuck_mode = v.stuck;
      model_clear();
      pulse_start();
      chk({nm, "_start_active"}, 32'(ACTIVE), 32'd1);
      chk({nm, "_start_err_clr"}, 32'(ERR), 32'd0);
      chk({nm, "_start_done_clr"}, 32'(DONE), 32'd0);
      wait_idle(nm, 2000);
      tick();
      chk({nm, "_strobes"}, 32'(strobe_cnt), 32'(v.n_strobe));
      if (v.n_strobe >= 1) chk({nm, "_data0"}, 32'(strobe_log[0]), 32'(v.d0));
      if (v.n_strobe >= 2) chk({nm, "_data1"}, 32'(strobe_log[1]), 32'(v.d1));
      chk({nm, "_done"}, 32'(DONE), 32'(v.done));
      chk({nm, "_err"}, 32'(ERR), 32'(v.err));
      chk({nm, "_addr"}, 32'(TBL_ADDR), 32'(v.addr));
      chk({nm, "_double_strobe"}, 32'(dbl_cnt), 32'd0);
   endtask

   initial begin
      int c;
      n_chk      = 0;
      n_fail     = 0;
      RST_N      = 1'b0;
      START      = 1'b0;
      model_rst  = 1'b1;
      stuck_mode = 1'b0;
      for (int i = 0; i < 4; i++) rom[i] = 24'h0;

      //           e0          e1          e2          e3          stuck n  d0          d1          done err addr
      vecs[0] = mk(24'h421280, 24'h421101, 24'hFF0000, 24'h000000, 1'b0, 2, 24'h421280, 24'h421101, 1'b1, 1'b0, 2'd2);
      vecs[1] = mk(24'hFE0000, 24'hFE0003, 24'hFF0000, 24'h000000, 1'b0, 0, 24'h0,      24'h0,      1'b1, 1'b0, 2'd2);
      vecs[2] = mk(24'h420101, 24'h420202, 24'h420303, 24'h420404, 1'b0, 4, 24'h420101, 24'h420202, 1'b1, 1'b0, 2'd3);
      vecs[3] = mk(24'h421280, 24'hFF0000, 24'h000000, 24'h000000, 1'b1, 1, 24'h421280, 24'h0,      1'b0, 1'b1, 2'd0);
      vecs[4] = mk(24'hFF0000, 24'h421280, 24'h000000, 24'h000000, 1'b0, 0, 24'h0,      24'h0,      1'b1, 1'b0, 2'd0);

      #12;
      chk("rst_active", 32'(ACTIVE), 32'd0);
      chk("rst_done", 32'(DONE), 32'd0);
      chk("rst_err", 32'(ERR), 32'd0);
      chk("rst_addr", 32'(TBL_ADDR), 32'd0);
      chk("rst_wdata", 32'(IIC_WDATA), 32'd0);
      chk("rst_wenbl", 32'(IIC_WENBL), 32'd0);
      tick();
      RST_N     = 1'b1;
      model_rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("idle_after_rst", 32'(ACTIVE), 32'd0);

      for (int i = 0; i < 5; i++) run_vec(i);

      // delay timing: DELAY is entered 2 edges after the START edge, then lasts 3*10 cycles
      load_rom({24'h0, 24'h0, 24'hFF0000, 24'hFE0003});
      stuck_mode = 1'b0;
      model_clear();
      pulse_start();
      c = 0;
      while (!DONE && c < 200) begin
         tick();
         c++;
      end
      chk("delay_done", 32'(DONE), 32'd1);
      chk_range("delay_len_from_entry", c - 2, 27, 33);
      chk("delay_no_strobe", 32'(strobe_cnt), 32'd0);

      // timeout: WAITBUSY entered 4 edges after START, ERR after 100 WAITBUSY cycles
      load_rom({24'h0, 24'h0, 24'hFF0000, 24'h421280});
      stuck_mode = 1'b1;
      model_clear();
      pulse_start();
      c = 0;
      while (!ERR && c < 400) begin
         tick();
         c++;
      end
      chk("timeout_cycle", 32'(c), 32'd104);
      chk("timeout_err", 32'(ERR), 32'd1);
      chk("timeout_done", 32'(DONE), 32'd0);
      chk("timeout_active", 32'(ACTIVE), 32'd0);
      stuck_mode = 1'b0;
      model_clear();
      pulse_start();
      chk("restart_clears_err", 32'(ERR), 32'd0);
      wait_idle("restart", 500);

      // START while running: second write is in flight at address 1
      load_rom({24'h0, 24'hFF0000, 24'h421101, 24'h421280});
      model_clear();
      pulse_start();
      for (int i = 0; i < 80; i++) tick();
      pulse_start();
      chk("restart_ignored_addr", 32'(TBL_ADDR), 32'd1);
      chk("restart_ignored_active", 32'(ACTIVE), 32'd1);
      wait_idle("busy_start", 1000);
      chk("busy_start_strobes", 32'(strobe_cnt), 32'd2);
      chk("busy_start_addr", 32'(TBL_ADDR), 32'd2);
      chk("busy_start_done", 32'(DONE), 32'd1);

      // asynchronous reset in the middle of a delay
      load_rom({24'h0, 24'hFF0000, 24'h421280, 24'hFE0003});
      model_clear();
      pulse_start();
      for (int i = 0; i < 10; i++) tick();
      chk("mid_delay_active", 32'(ACTIVE), 32'd1);
      chk("wdata_held", 32'(IIC_WDATA), 32'h421101);
      #2 RST_N = 1'b0;
      #1;
      chk("async_rst_active", 32'(ACTIVE), 32'd0);
      chk("async_rst_addr", 32'(TBL_ADDR), 32'd0);
      chk("async_rst_wdata", 32'(IIC_WDATA), 32'd0);
      chk("async_rst_done", 32'(DONE), 32'd0);
      chk("async_rst_err", 32'(ERR), 32'd0);
      tick();
      RST_N = 1'b1;
      for (int i = 0; i < 100; i++) tick();
      chk("post_rst_no_strobe", 32'(strobe_cnt), 32'd0);
      chk("post_rst_active", 32'(ACTIVE), 32'd0);
      chk("post_rst_done", 32'(DONE), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
